hack_alu: RTL and testbench

- Registered Hack-style ALU for the CPU datapath, between the register file / A-M mux and the writeback and jump logic.
- Computes one of the Hack function set on two WIDTH-bit operands, selected by six control bits (zx, nx, zy, ny, f, no).
- Produces the result plus zero and negative flags, one clock after the inputs are accepted.

---
 rtl/hack_alu.sv | 106 ++++++++++
 tb/tb_hack_alu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu.sv
// Registered Hack-style ALU: result plus zero/negative flags one cycle after in_valid.
// Define HACK_ALU_OVF_EN to add registered carry-out (co) and signed-overflow (ov) outputs.
module hack_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  output logic [WIDTH-1:0] o,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_OVF_EN
  ,
  output logic             co,
  output logic             ov
`endif
);

  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_x2;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_y2;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_res;
  logic             w_zr;
  logic             w_ng;

  logic             r_valid;
  logic [WIDTH-1:0] r_o;
  logic             r_zr;
  logic             r_ng;

  // Zeroing via a mux (not AND) so an undriven operand cannot leak X when masked.
  assign w_x1 = zx ? '0 : x;
  assign w_x2 = nx ? ~w_x1 : w_x1;
  assign w_y1 = zy ? '0 : y;
  assign w_y2 = ny ? ~w_y1 : w_y1;

`ifdef HACK_ALU_OVF_EN
  logic [WIDTH:0] w_sum;
  logic           w_co;
  logic           w_ov;
  logic           r_co;
  logic           r_ov;

  assign w_sum = {1'b0, w_x2} + {1'b0, w_y2};
  // Both taken from the raw adder, before the output inversion.
  assign w_co  = f & w_sum[WIDTH];
  assign w_ov  = f & (w_x2[WIDTH-1] == w_y2[WIDTH-1]) & (w_sum[WIDTH-1] != w_x2[WIDTH-1]);
`else
  logic [WIDTH-1:0] w_sum;

  assign w_sum = w_x2 + w_y2;
`endif

  assign w_r   = f ? w_sum[WIDTH-1:0] : (w_x2 & w_y2);
  assign w_res = no ? ~w_r : w_r;
  assign w_zr  = (w_res == '0);
  assign w_ng  = w_res[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_o     <= '0;
      r_zr    <= 1'b1;
      r_ng    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_o  <= w_res;
        r_zr <= w_zr;
        r_ng <= w_ng;
      end
    end
  end

`ifdef HACK_ALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_co <= 1'b0;
      r_ov <= 1'b0;
    end else if (in_valid) begin
      r_co <= w_co;
      r_ov <= w_ov;
    end
  end

  assign co = r_co;
  assign ov = r_ov;
`endif

  assign out_valid = r_valid;
  assign o         = r_o;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: directed plan vectors plus randomized ops vs a reference model.
// Covers the optional co/ov outputs when HACK_ALU_OVF_EN is defined.
module tb_hack_alu;

  localparam int unsigned W = 16;
  localparam int unsigned M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         zx, nx, zy, ny, f, no;
  logic         out_valid;
  logic [W-1:0] o;
  logic         zr;
  logic         ng;
`ifdef HACK_ALU_OVF_EN
  logic         co;
  logic         ov;
`endif

  int n_vec;
  int n_err;

  hack_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out_valid (out_valid),
    .o         (o),
    .zr        (zr),
    .ng        (ng)
`ifdef HACK_ALU_OVF_EN
    ,
    .co        (co),
    .ov        (ov)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: operands as unsigned integers, negation as (M-1-v), sum checked against range.
  function automatic int unsigned ref_res(input int unsigned xv, input int unsigned yv,
                                          input logic [5:0] c);
    int unsigned a, b, r;
    a = c[5] ? 0 : xv;
    if (c[4]) a = M - 1 - a;
    b = c[3] ? 0 : yv;
    if (c[2]) b = M - 1 - b;
    r = c[1] ? (a + b) % M : (a & b);
    if (c[0]) r = M - 1 - r;
    return r;
  endfunction

  function automatic logic [1:0] ref_cov(input int unsigned xv, input int unsigned yv,
                                         input logic [5:0] c);
    int unsigned a, b;
    int sa, sb, ss;
    logic cc, vv;
    a = c[5] ? 0 : xv;
    if (c[4]) a = M - 1 - a;
    b = c[3] ? 0 : yv;
    if (c[2]) b = M - 1 - b;
    sa = (a >= M / 2) ? int'(a) - int'(M) : int'(a);
    sb = (b >= M / 2) ? int'(b) - int'(M) : int'(b);
    ss = sa + sb;
    cc = c[1] && ((a + b) >= M);
    vv = c[1] && ((ss < -int'(M / 2)) || (ss >= int'(M / 2)));
    return {cc, vv};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [5:0] c);
    in_valid = v;
    x        = xv;
    y        = yv;
    {zx, nx, zy, ny, f, no} = c;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'h8000, 16'h0000, 6'b000010);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 6'b000000);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, o, zr, ng} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: got v=%b o=%h zr=%b ng=%b, want v=0 o=0000 zr=1 ng=0",
               out_valid, o, zr, ng);
    end
    drive(1'b1, 16'h1234, 16'h4321, 6'b000010);
    step();
    n_vec++;
    if ({out_valid, o, zr, ng} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_held: got v=%b o=%h zr=%b ng=%b, want v=0 o=0000 zr=1 ng=0",
               out_valid, o, zr, ng);
    end
`ifdef HACK_ALU_OVF_EN
    n_vec++;
    if ({co, ov} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_cov: got co=%b ov=%b, want 0 0", co, ov);
    end
`endif
    drive(1'b0, 16'h0000, 16'h0000, 6'b000000);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_plan_vectors();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    logic [5:0]   cs[4];
    logic [W-1:0] os[4];
    xs = '{16'hC979, 16'h0000, 16'h8B17, 16'hE38E};
    ys = '{16'hBEFF, 16'h9E96, 16'h1C1C, 16'hE38E};
    cs = '{6'b000010, 6'b001110, 6'b010101, 6'b000111};
    os = '{16'h8878, 16'hFFFF, 16'h9F1F, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i], cs[i]);
      step();
      n_vec++;
      if ({out_valid, o, zr, ng} !== {1'b1, os[i], os[i] == 16'h0000, os[i][15]}) begin
        n_err++;
        $display("FAIL plan_%0d: got v=%b o=%h zr=%b ng=%b, want v=1 o=%h zr=%b ng=%b",
                 i, out_valid, o, zr, ng, os[i], os[i] == 16'h0000, os[i][15]);
      end
`ifdef HACK_ALU_OVF_EN
      if (i == 0) begin
        n_vec++;
        if ({co, ov} !== 2'b10) begin
          n_err++;
          $display("FAIL plan_add_cov: got co=%b ov=%b, want co=1 ov=0", co, ov);
        end
      end
`endif
    end
    drive(1'b0, 16'h0000, 16'h0000, 6'b000000);
    step();
  endtask

  task automatic test_back_to_back();
    logic         ev[5];
    logic [W-1:0] eo[5];
    ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    eo = '{16'h8878, 16'h9F1F, 16'h9F1F, 16'h9F1F, 16'h9F1F};
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(1'b1, 16'hC979, 16'hBEFF, 6'b000010);
      else if (i == 1) drive(1'b1, 16'h8B17, 16'h1C1C, 6'b010101);
      else             drive(1'b0, 16'h0F0F, 16'h0000, 6'b000011);
      step();
      n_vec++;
      if ({out_valid, o} !== {ev[i], eo[i]}) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: got v=%b o=%h, want v=%b o=%h",
                 i, out_valid, o, ev[i], eo[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 16'h1111, 16'h2222, 6'b000010);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 6'b000000);
    step();
    n_vec++;
    if ({out_valid, o, zr} !== {1'b0, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL midop_discard: got v=%b o=%h zr=%b, want v=0 o=0000 zr=1",
               out_valid, o, zr);
    end
    drive(1'b1, 16'h1111, 16'h2222, 6'b000010);
    step();
    n_vec++;
    if ({out_valid, o} !== {1'b1, 16'h3333}) begin
      n_err++;
      $display("FAIL midop_first: got v=%b o=%h, want v=1 o=3333", out_valid, o);
    end
  endtask

`ifdef HACK_ALU_OVF_EN
  task automatic test_overflow();
    drive(1'b1, 16'h7FFF, 16'h0001, 6'b000010);
    step();
    n_vec++;
    if ({o, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL overflow: got o=%h co=%b ov=%b, want o=8000 co=0 ov=1", o, co, ov);
    end
  endtask
`endif

  task automatic test_random();
    logic         ev;
    logic [W-1:0] eo;
    logic [1:0]   ecv;
    logic         v;
    logic [W-1:0] xv, yv;
    logic [5:0]   c;
    int unsigned  r;
    ev  = 1'b0;
    eo  = o;
    ecv = 2'b00;
`ifdef HACK_ALU_OVF_EN
    ecv = {co, ov};
`endif
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      xv = W'($urandom);
      yv = W'($urandom);
      c  = 6'($urandom);
      drive(v, xv, yv, c);
      // Masked operands driven as X must not reach the result.
      if (c[5] && i[0]) x = 'x;
      if (c[3] && i[1]) y = 'x;
      if (v) begin
        r   = ref_res(int'(xv), int'(yv), c);
        eo  = W'(r);
        ecv = ref_cov(int'(xv), int'(yv), c);
      end
      ev = v;
      step();
      n_vec++;
      if ({out_valid, o, zr, ng} !== {ev, eo, eo == '0, eo[W-1]}) begin
        n_err++;
        $display("FAIL rand_%0d: got v=%b o=%h zr=%b ng=%b, want v=%b o=%h zr=%b ng=%b",
                 i, out_valid, o, zr, ng, ev, eo, eo == '0, eo[W-1]);
      end
`ifdef HACK_ALU_OVF_EN
      n_vec++;
      if ({co, ov} !== ecv) begin
        n_err++;
        $display("FAIL rand_cov_%0d: got co=%b ov=%b, want co=%b ov=%b",
                 i, co, ov, ecv[1], ecv[0]);
      end
`endif
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 6'b000000);
    #12 rst_n = 1'b1;
    step();
    test_reset();
    test_plan_vectors();
    test_back_to_back();
    test_reset_midop();
`ifdef HACK_ALU_OVF_EN
    test_overflow();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
